// File: rtl/simple_response_serializer.sv
// Serializes one {cmd, addr, value} response frame into a valid/ready word stream, cmd first.
// Define RESP_CHECKSUM_EN to append an XOR checksum word after the last value word.
module simple_response_serializer #(
    parameter int unsigned WORD_WIDTH  = 8,
    parameter int unsigned VALUE_WORDS = 4
) (
    input  logic                                  clk,
    input  logic                                  i_reset,
    input  logic [(VALUE_WORDS+2)*WORD_WIDTH-1:0] i_data,
    input  logic                                  i_valid,
    output logic                                  o_ready,
    output logic [WORD_WIDTH-1:0]                 o_word,
    output logic                                  o_word_valid,
    input  logic                                  i_word_ready,
    output logic                                  o_busy,
    output logic                                  o_done,
    output logic                                  o_overrun
);

    localparam int unsigned N    = VALUE_WORDS + 2;
    localparam int unsigned IdxW = $clog2(N + 1);
    localparam logic [IdxW-1:0] LastIdx = IdxW'(N - 1);

`ifdef RESP_CHECKSUM_EN
    typedef enum logic [1:0] {StIdle, StSend, StCsum} state_e;
`else
    typedef enum logic [0:0] {StIdle, StSend} state_e;
`endif

    state_e                    state_q, state_d;
    logic [IdxW-1:0]           idx_q, idx_d;
    logic [N*WORD_WIDTH-1:0]   frame_q, frame_d;
    logic                      done_q, done_d;
    logic [WORD_WIDTH-1:0]     words [N];
    logic [WORD_WIDTH-1:0]     cur_word;
`ifdef RESP_CHECKSUM_EN
    logic [WORD_WIDTH-1:0]     xor_q, xor_d;
`endif

    // Word 0 is the top (cmd) slice of the latched frame.
    always_comb begin
        for (int i = 0; i < int'(N); i++) begin
            words[i] = frame_q[(int'(N) - 1 - i)*int'(WORD_WIDTH) +: WORD_WIDTH];
        end
        cur_word = (idx_q <= LastIdx) ? words[idx_q] : '0;
    end

    always_ff @(posedge clk) begin
        if (i_reset) begin
            state_q <= StIdle;
            idx_q   <= '0;
            frame_q <= '0;
            done_q  <= 1'b0;
`ifdef RESP_CHECKSUM_EN
            xor_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            frame_q <= frame_d;
            done_q  <= done_d;
`ifdef RESP_CHECKSUM_EN
            xor_q   <= xor_d;
`endif
        end
    end

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        frame_d      = frame_q;
        done_d       = 1'b0;
`ifdef RESP_CHECKSUM_EN
        xor_d        = xor_q;
`endif
        o_ready      = 1'b0;
        o_word       = '0;
        o_word_valid = 1'b0;
        o_overrun    = 1'b0;

        case (state_q)
            StIdle: begin
                o_ready = 1'b1;
                if (i_valid) begin
                    frame_d = i_data;
                    idx_d   = '0;
                    state_d = StSend;
`ifdef RESP_CHECKSUM_EN
                    xor_d   = '0;
`endif
                end
            end
            StSend: begin
                o_word_valid = 1'b1;
                o_word       = cur_word;
                o_overrun    = i_valid;
                if (i_word_ready) begin
`ifdef RESP_CHECKSUM_EN
                    xor_d = xor_q ^ cur_word;
`endif
                    if (idx_q == LastIdx) begin
`ifdef RESP_CHECKSUM_EN
                        state_d = StCsum;
`else
                        state_d = StIdle;
                        done_d  = 1'b1;
`endif
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
`ifdef RESP_CHECKSUM_EN
            StCsum: begin
                o_word_valid = 1'b1;
                o_word       = xor_q;
                o_overrun    = i_valid;
                if (i_word_ready) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end
            end
`endif
            default: state_d = StIdle;
        endcase
    end

    assign o_busy = (state_q != StIdle);
    assign o_done = done_q;

endmodule

// File: tb/tb_simple_response_serializer.sv
// Randomized and directed bench for simple_response_serializer, checked against a queue-based
// frame model. Define RESP_CHECKSUM_EN to expect the trailing XOR word.
module tb_simple_response_serializer;

    localparam int W  = 8;
    localparam int VW = 4;
    localparam int N  = VW + 2;
`ifdef RESP_CHECKSUM_EN
    localparam int FLEN = N + 1;
`else
    localparam int FLEN = N;
`endif

    logic             clk = 1'b0;
    logic             i_reset = 1'b1;
    logic [N*W-1:0]   i_data = '0;
    logic             i_valid = 1'b0;
    logic             o_ready;
    logic [W-1:0]     o_word;
    logic             o_word_valid;
    logic             i_word_ready = 1'b1;
    logic             o_busy;
    logic             o_done;
    logic             o_overrun;

    int n_cmp = 0;
    int n_bad = 0;

    simple_response_serializer #(
        .WORD_WIDTH  (W),
        .VALUE_WORDS (VW)
    ) dut (
        .clk          (clk),
        .i_reset      (i_reset),
        .i_data       (i_data),
        .i_valid      (i_valid),
        .o_ready      (o_ready),
        .o_word       (o_word),
        .o_word_valid (o_word_valid),
        .i_word_ready (i_word_ready),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_overrun    (o_overrun)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: words still owed by the frame in flight, and a pending done pulse.
    logic [W-1:0] exp_q [$];
    int           rem = 0;
    bit           done_pend = 1'b0;
    bit           mon_en = 1'b0;
    bit           rst_prev = 1'b0;

    function automatic void push_frame(input logic [N*W-1:0] d);
        logic [W-1:0] x;
        logic [W-1:0] w;
        x = '0;
        for (int i = 0; i < N; i++) begin
            w = d[(N-1-i)*W +: W];
            exp_q.push_back(w);
            x = x ^ w;
        end
`ifdef RESP_CHECKSUM_EN
        exp_q.push_back(x);
`endif
    endfunction

    always @(negedge clk) begin
        if (mon_en) begin
            check_eq("ready", o_ready, rem == 0);
            check_eq("busy", o_busy, rem != 0);
            check_eq("word_valid", o_word_valid, rem != 0);
            check_eq("done", o_done, done_pend);
            check_eq("overrun", o_overrun, i_valid && rem != 0);
            if (rem != 0 && o_word_valid) check_eq("word", o_word, exp_q[0]);
            if (rst_prev) check_eq("rst_word", o_word, 0);
            rst_prev = i_reset;
            done_pend = 1'b0;
            if (i_reset) begin
                rem = 0;
                exp_q.delete();
            end else if (rem != 0) begin
                if (i_word_ready) begin
                    void'(exp_q.pop_front());
                    rem--;
                    if (rem == 0) done_pend = 1'b1;
                end
            end else if (i_valid) begin
                push_frame(i_data);
                rem = FLEN;
            end
        end
    end

    // Downstream ready: 0 = always, 1 = pattern 1,0,0,1, 2 = random.
    int rdy_mode = 0;
    int pidx = 0;
    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            1: begin
                i_word_ready = (pidx % 4 == 0) || (pidx % 4 == 3);
                pidx++;
            end
            2: i_word_ready = 1'($urandom_range(0, 1));
            default: i_word_ready = 1'b1;
        endcase
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [N*W-1:0] d, input int hold);
        int cyc;
        cyc = 0;
        step();
        while (!o_ready && cyc < 200) begin
            step();
            cyc++;
        end
        if (!o_ready) check_eq("ready_timeout", 0, 1);
        i_data  = d;
        i_valid = 1'b1;
        repeat (hold) step();
        i_valid = 1'b0;
    endtask

    task automatic wait_done(input bit launch, input logic [N*W-1:0] d);
        int cyc;
        cyc = 0;
        while (!o_done && cyc < 200) begin
            step();
            cyc++;
        end
        if (!o_done) check_eq("done_timeout", 0, 1);
        if (launch) begin
            i_data  = d;
            i_valid = 1'b1;
            step();
            i_valid = 1'b0;
        end
    endtask

    initial begin
        logic [N*W-1:0] f;
        int hs;
        step();
        mon_en = 1'b1;
        step();
        i_reset = 1'b0;
        step();

        // Basic frame, then backpressure pattern.
        send_frame(48'h02_05_DEADBEEF, 1);
        wait_done(1'b0, '0);
        rdy_mode = 1;
        send_frame(48'h02_05_DEADBEEF, 1);
        wait_done(1'b0, '0);
        rdy_mode = 0;

        // Overrun while sending.
        send_frame(48'h02_05_DEADBEEF, 1);
        step();
        i_data  = 48'hAA_01_00000001;
        i_valid = 1'b1;
        step();
        i_valid = 1'b0;
        wait_done(1'b0, '0);

        // Back-to-back: new frame launched on the done cycle.
        send_frame(48'h11_22_33445566, 1);
        wait_done(1'b1, 48'h77_88_99AABBCC);
        wait_done(1'b0, '0);

        // Reset after the third handshake.
        send_frame(48'h02_05_DEADBEEF, 1);
        hs = 0;
        for (int c = 0; c < 50 && hs < 3; c++) begin
            @(negedge clk);
            if (o_word_valid && i_word_ready) hs++;
        end
        if (hs < 3) check_eq("hs_timeout", 0, 1);
        step();
        i_reset = 1'b1;
        step();
        i_reset = 1'b0;
        repeat (2) step();
        send_frame(48'h5A_A5_01020304, 1);
        wait_done(1'b0, '0);

        // Randomized frames, backpressure, held valid and stray overrun pulses.
        rdy_mode = 2;
        for (int k = 0; k < 30; k++) begin
            f = {$urandom, $urandom};
            send_frame(f, int'($urandom_range(1, 2)));
            if ($urandom_range(0, 2) == 0) begin
                i_data  = {$urandom, $urandom};
                i_valid = 1'b1;
                step();
                i_valid = 1'b0;
            end
            if ($urandom_range(0, 1) == 0) wait_done(1'b0, '0);
        end
        wait_done(1'b0, '0);
        repeat (3) step();
        check_eq("queue_empty", 64'(exp_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/simple_response_serializer.md
Name: simple_response_serializer

Overview:
- Transmit-side counterpart of the command controller.
- Takes one parallel response frame {command, address, value} and emits it one word at a time, first word first, over a valid/ready word stream toward the byte transmitter.
- Word order on the stream is the same C A V…V order the receive side expects: command, then address, then value words from most-significant to least-significant.
- Holds one frame at a time. Reports completion and reports frames rejected because the block was busy.

Parameters:
- WORD_WIDTH, 8: bits per stream word. Also the width of the command and address fields.
- VALUE_WORDS, 4: number of words in the value field.

Ports:
- clk  input  1  clock; all logic on its rising edge
- i_reset  input  1  reset, synchronous, active-high
- i_data  input  (VALUE_WORDS+2)*WORD_WIDTH  frame; top word = cmd, next word = addr, low VALUE_WORDS words = value, MSW first
- i_valid  input  1  frame-valid request
- o_ready  output  1  high when a frame can be accepted (state IDLE)
- o_word  output  WORD_WIDTH  current stream word
- o_word_valid  output  1  o_word is valid
- i_word_ready  input  1  downstream accepts o_word this cycle
- o_busy  output  1  frame in progress (state != IDLE)
- o_done  output  1  one-cycle pulse after the final word handshake
- o_overrun  output  1  one-cycle pulse when i_valid is high while not ready; that frame is dropped

Behaviour:
- Reset (synchronous, active-high, dominates everything): state IDLE, word index 0, frame register 0. Outputs after reset: o_ready=1, o_word=0, o_word_valid=0, o_busy=0, o_done=0, o_overrun=0.
- States: IDLE, SEND (plus CSUM when the optional feature is compiled in).
- Frame length N = VALUE_WORDS+2 words.
- IDLE:
  - o_ready=1.
  - If i_valid is high: latch i_data, set index=0, go to SEND.
  - o_word_valid rises the next cycle, giving 1-cycle latency from accept to first word.
- SEND:
  - o_word = latched word[index], where index 0 is the top word (cmd). o_word_valid=1.
  - Handshake occurs when o_word_valid && i_word_ready.
  - On handshake with index < N-1: index increments.
  - On handshake with index = N-1: go to IDLE and pulse o_done in the following cycle.
  - While i_word_ready=0, o_word and o_word_valid hold stable; no word is skipped or repeated.
- o_done is registered. It is high in the first IDLE cycle after the final handshake.
  - A new frame can be accepted in that same cycle. Back-to-back frames therefore have exactly one bubble cycle with no valid word.
- i_valid while in SEND: frame ignored, o_overrun pulses for that cycle. The in-flight frame is unaffected.
- i_valid held high across the IDLE accept: only the accepting cycle takes the frame. Later cycles in SEND raise o_overrun.
  - Upstream must drop i_valid after o_ready falls.
- Reset mid-frame: the frame is aborted, o_word_valid=0 the cycle after reset, and no o_done is produced.
- i_word_ready while o_word_valid=0: ignored.
- Index counter width is clog2(N+1). It wraps to 0 only through the IDLE accept, never by overflow.

Optional Feature:
- Macro: RESP_CHECKSUM_EN.
- Defined:
  - After the last value word is accepted, the block enters CSUM and sends one extra word.
  - That word is the XOR of all N frame words, computed as a running XOR updated on each handshake.
  - o_done pulses after the checksum handshake instead of after the last value word. Frame length becomes N+1.
  - Backpressure rules in CSUM are the same as in SEND.
  - The running XOR clears on reset and on each accept.
- Undefined: no CSUM state, no XOR register, frame length N.

Test Plan (WORD_WIDTH=8, VALUE_WORDS=4):
- Basic frame: reset, i_data=0x02_05_DEADBEEF, one-cycle i_valid, i_word_ready held 1.
  - Expect words 02, 05, DE, AD, BE, EF on 6 consecutive cycles, starting 1 cycle after accept.
  - Expect o_done 1 cycle after EF; o_ready=1 again.
- Backpressure: same frame, i_word_ready toggled 1,0,0,1,…
  - Each word is held stable while ready=0.
  - Sequence is exactly 02, 05, DE, AD, BE, EF with no duplicates.
  - One o_done.
- Overrun: while sending, pulse i_valid with 0xAA_01_00000001.
  - o_overrun pulses 1 cycle; current frame completes unchanged; 0xAA never appears.
- Back-to-back: assert i_valid with a new frame on the o_done cycle.
  - The new frame is accepted; its cmd word appears the next cycle, with exactly one bubble cycle.
- Reset mid-frame: assert i_reset after the 3rd handshake (DE).
  - o_word_valid=0 next cycle, no o_done, o_ready=1.
  - A subsequent frame starts cleanly at its cmd word.
- RESP_CHECKSUM_EN defined: basic frame.
  - Expect 7 words: 02, 05, DE, AD, BE, EF, 25.
  - o_done after the checksum word.
